// File: rtl/music_pkg.sv
// Song RAM format shared by the recorder and the playback unit: field widths,
// reserved codes and the recorder state encoding.
package music_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned TONE_W = 7;
    localparam int unsigned NOTE_W = 7;

    localparam logic [TONE_W-1:0] REST_TONE = {TONE_W{1'b0}};
    localparam logic [NOTE_W-1:0] END_NOTE  = {NOTE_W{1'b0}};
    localparam logic [NOTE_W-1:0] NOTE_ZERO = {NOTE_W{1'b0}};
    localparam logic [NOTE_W-1:0] NOTE_ONE  = {{(NOTE_W-1){1'b0}}, 1'b1};
    localparam logic [NOTE_W-1:0] NOTE_MAX  = {NOTE_W{1'b1}};

    localparam logic [ADDR_W-1:0] ADDR_ZERO      = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE       = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] MAX_ADDR       = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] LAST_DATA_ADDR = MAX_ADDR - ADDR_ONE;

    typedef enum logic [2:0] {
        REC_IDLE    = 3'd0,
        REC_ARMED   = 3'd1,
        REC_CAPTURE = 3'd2,
        REC_FLUSH   = 3'd3,
        REC_TERM    = 3'd4,
        REC_DONE    = 3'd5
    } rec_state_e;

    // A zero-TICK run still occupies one TICK when it is stored.
    function automatic logic [NOTE_W-1:0] round_up_note(input logic [NOTE_W-1:0] n);
        return (n == NOTE_ZERO) ? NOTE_ONE : n;
    endfunction

endpackage

// File: rtl/note_timer.sv
// Duration counter for the run being captured: counts TICKs, flags saturation at
// NOTE_MAX and restarts at one so a long note splits into back-to-back entries.
module note_timer
    import music_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_i,
    input  logic              run_i,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [NOTE_W-1:0] load_val_i,
    output logic [NOTE_W-1:0] cnt_o,
    output logic [NOTE_W-1:0] eff_o,
    output logic              sat_o
);

    logic [NOTE_W-1:0] cnt_d;
    logic [NOTE_W-1:0] cnt_q;
    logic [NOTE_W-1:0] eff_s;
    logic              sat_s;

    // eff_s is the run length including a TICK arriving this cycle, capped at NOTE_MAX.
    always_comb begin
        sat_s = (cnt_q == NOTE_MAX);
        if (tick_i && !sat_s) begin
            eff_s = cnt_q + NOTE_ONE;
        end else begin
            eff_s = cnt_q;
        end
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (clr_i) begin
            cnt_d = NOTE_ZERO;
        end else if (run_i && tick_i) begin
            cnt_d = sat_s ? NOTE_ONE : (cnt_q + NOTE_ONE);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= NOTE_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign eff_o = eff_s;
    assign sat_o = sat_s;

endmodule

// File: rtl/music_recorder.sv
// Records live keyboard play into the song RAM as {tone, duration} runs ended by {0,0}.
// Build option MUSIC_REC_GLITCH_FILTER_EN drops zero-TICK runs instead of storing them as 1.
module music_recorder
    import music_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              TICK,
    input  logic [TONE_W-1:0] TONE_IN,
    output logic              WrEn,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [TONE_W-1:0] WrTone,
    output logic [NOTE_W-1:0] WrNote,
    output logic              RECORDING,
    output logic              FULL,
    output logic [ADDR_W-1:0] LENGTH
);

    rec_state_e        state_d, state_q;
    logic [TONE_W-1:0] tone_d, tone_q;
    logic              en_d, en_q;
    logic [TONE_W-1:0] cur_tone_d, cur_tone_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic              full_d, full_q;
    logic              recording_d, recording_q;
    logic              wr_en_d, wr_en_q;
    logic [ADDR_W-1:0] wr_addr_d, wr_addr_q;
    logic [TONE_W-1:0] wr_tone_d, wr_tone_q;
    logic [NOTE_W-1:0] wr_note_d, wr_note_q;
`ifdef MUSIC_REC_GLITCH_FILTER_EN
    logic              pend_v_d, pend_v_q;
    logic [TONE_W-1:0] pend_tone_d, pend_tone_q;
    logic [NOTE_W-1:0] pend_note_d, pend_note_q;
`endif

    logic              en_rise_s;
    logic              change_s;
    logic              data_wr_s;
    logic [TONE_W-1:0] data_tone_s;
    logic [NOTE_W-1:0] data_note_s;
    logic              tmr_run_s;
    logic              tmr_clr_s;
    logic              tmr_load_s;
    logic [NOTE_W-1:0] tmr_load_val_s;
    logic [NOTE_W-1:0] tmr_cnt_s;
    logic [NOTE_W-1:0] tmr_eff_s;
    logic              tmr_sat_s;

    note_timer u_note_timer (
        .clk        (CLK),
        .rst_n      (RST),
        .tick_i     (TICK),
        .run_i      (tmr_run_s),
        .clr_i      (tmr_clr_s),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_load_val_s),
        .cnt_o      (tmr_cnt_s),
        .eff_o      (tmr_eff_s),
        .sat_o      (tmr_sat_s)
    );

    assign en_rise_s = EN && !en_q;
    assign change_s  = (tone_q != cur_tone_q);

    // Next-state, run bookkeeping and the single RAM write port mux.
    always_comb begin
        state_d        = state_q;
        tone_d         = TONE_IN;
        en_d           = EN;
        cur_tone_d     = cur_tone_q;
        addr_d         = addr_q;
        full_d         = full_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_tone_d      = wr_tone_q;
        wr_note_d      = wr_note_q;
        data_wr_s      = 1'b0;
        data_tone_s    = cur_tone_q;
        data_note_s    = tmr_cnt_s;
        tmr_run_s      = 1'b0;
        tmr_clr_s      = 1'b0;
        tmr_load_s     = 1'b0;
        tmr_load_val_s = NOTE_ZERO;
`ifdef MUSIC_REC_GLITCH_FILTER_EN
        pend_v_d       = pend_v_q;
        pend_tone_d    = pend_tone_q;
        pend_note_d    = pend_note_q;
`endif

        case (state_q)
            REC_IDLE, REC_DONE: begin
                if (en_rise_s) begin
                    state_d = REC_ARMED;
                    addr_d  = ADDR_ZERO;
                    full_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            REC_ARMED: begin
                if (!EN) begin
                    state_d = REC_TERM;
                end else if (tone_q != REST_TONE) begin
                    state_d    = REC_CAPTURE;
                    cur_tone_d = tone_q;
                    tmr_clr_s  = 1'b1;
`ifdef MUSIC_REC_GLITCH_FILTER_EN
                    pend_v_d   = 1'b0;
`endif
                end else begin
                    state_d = REC_ARMED;
                end
            end
            REC_CAPTURE: begin
                if (!EN) begin
                    state_d = REC_FLUSH;
                end else if (change_s) begin
                    cur_tone_d = tone_q;
                    tmr_clr_s  = 1'b1;
`ifdef MUSIC_REC_GLITCH_FILTER_EN
                    // Finished runs wait one run in pend_* so a dropped glitch can merge back.
                    if (tmr_eff_s == NOTE_ZERO) begin
                        if (pend_v_q && (pend_tone_q == tone_q)) begin
                            tmr_clr_s      = 1'b0;
                            tmr_load_s     = 1'b1;
                            tmr_load_val_s = pend_note_q;
                            pend_v_d       = 1'b0;
                        end else begin
                            pend_v_d = pend_v_q;
                        end
                    end else begin
                        if (pend_v_q) begin
                            data_wr_s   = 1'b1;
                            data_tone_s = pend_tone_q;
                            data_note_s = pend_note_q;
                        end else begin
                            data_wr_s = 1'b0;
                        end
                        pend_v_d    = 1'b1;
                        pend_tone_d = cur_tone_q;
                        pend_note_d = tmr_eff_s;
                    end
`else
                    data_wr_s   = 1'b1;
                    data_tone_s = cur_tone_q;
                    data_note_s = round_up_note(tmr_eff_s);
`endif
                end else if (TICK) begin
                    tmr_run_s = 1'b1;
`ifdef MUSIC_REC_GLITCH_FILTER_EN
                    if (pend_v_q) begin
                        data_wr_s   = 1'b1;
                        data_tone_s = pend_tone_q;
                        data_note_s = pend_note_q;
                        pend_v_d    = 1'b0;
                    end else if (tmr_sat_s) begin
                        data_wr_s   = 1'b1;
                        data_note_s = NOTE_MAX;
                    end else begin
                        data_wr_s = 1'b0;
                    end
`else
                    if (tmr_sat_s) begin
                        data_wr_s   = 1'b1;
                        data_note_s = NOTE_MAX;
                    end else begin
                        data_wr_s = 1'b0;
                    end
`endif
                end else begin
                    tmr_run_s = 1'b0;
                end
            end
            REC_FLUSH: begin
                state_d = REC_TERM;
`ifdef MUSIC_REC_GLITCH_FILTER_EN
                if (pend_v_q) begin
                    data_wr_s   = (pend_tone_q != REST_TONE);
                    data_tone_s = pend_tone_q;
                    data_note_s = pend_note_q;
                end else begin
                    data_wr_s = (cur_tone_q != REST_TONE) && (tmr_cnt_s != NOTE_ZERO);
                end
                pend_v_d = 1'b0;
`else
                data_wr_s   = (cur_tone_q != REST_TONE);
                data_note_s = round_up_note(tmr_cnt_s);
`endif
            end
            REC_TERM: begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_tone_d = REST_TONE;
                wr_note_d = END_NOTE;
                state_d   = REC_DONE;
            end
            default: begin
                state_d = REC_IDLE;
            end
        endcase

        if (data_wr_s) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_tone_d = data_tone_s;
            wr_note_d = data_note_s;
            addr_d    = addr_q + ADDR_ONE;
            if (addr_q == LAST_DATA_ADDR) begin
                full_d  = 1'b1;
                state_d = REC_TERM;
            end else begin
                full_d = full_q;
            end
        end else begin
            addr_d = addr_d;
        end

        recording_d = (state_d == REC_ARMED) || (state_d == REC_CAPTURE) ||
                      (state_d == REC_FLUSH) || (state_d == REC_TERM);
    end

    // All recorder state and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= REC_IDLE;
            tone_q      <= REST_TONE;
            en_q        <= 1'b0;
            cur_tone_q  <= REST_TONE;
            addr_q      <= ADDR_ZERO;
            full_q      <= 1'b0;
            recording_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= ADDR_ZERO;
            wr_tone_q   <= REST_TONE;
            wr_note_q   <= NOTE_ZERO;
`ifdef MUSIC_REC_GLITCH_FILTER_EN
            pend_v_q    <= 1'b0;
            pend_tone_q <= REST_TONE;
            pend_note_q <= NOTE_ZERO;
`endif
        end else begin
            state_q     <= state_d;
            tone_q      <= tone_d;
            en_q        <= en_d;
            cur_tone_q  <= cur_tone_d;
            addr_q      <= addr_d;
            full_q      <= full_d;
            recording_q <= recording_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_tone_q   <= wr_tone_d;
            wr_note_q   <= wr_note_d;
`ifdef MUSIC_REC_GLITCH_FILTER_EN
            pend_v_q    <= pend_v_d;
            pend_tone_q <= pend_tone_d;
            pend_note_q <= pend_note_d;
`endif
        end
    end

    assign WrEn      = wr_en_q;
    assign WrAddr    = wr_addr_q;
    assign WrTone    = wr_tone_q;
    assign WrNote    = wr_note_q;
    assign RECORDING = recording_q;
    assign FULL      = full_q;
    assign LENGTH    = addr_q;

endmodule

// File: tb/tb_music_recorder.sv
// Directed bench for music_recorder: captures every RAM write and compares it
// with hand-computed entry lists.
module tb_music_recorder;
    import music_pkg::*;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              EN = 1'b0;
    logic              TICK = 1'b0;
    logic [TONE_W-1:0] TONE_IN = 7'd0;
    logic              WrEn;
    logic [ADDR_W-1:0] WrAddr;
    logic [TONE_W-1:0] WrTone;
    logic [NOTE_W-1:0] WrNote;
    logic              RECORDING;
    logic              FULL;
    logic [ADDR_W-1:0] LENGTH;

    int n_cmp = 0;
    int n_err = 0;
    int wq[$];
    int eq[$];

    music_recorder dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .TICK      (TICK),
        .TONE_IN   (TONE_IN),
        .WrEn      (WrEn),
        .WrAddr    (WrAddr),
        .WrTone    (WrTone),
        .WrNote    (WrNote),
        .RECORDING (RECORDING),
        .FULL      (FULL),
        .LENGTH    (LENGTH)
    );

    always #5 CLK = ~CLK;

    function automatic int pack(input int a, input int t, input int n);
        return a * 16384 + t * 128 + n;
    endfunction

    always @(negedge CLK) begin
        if (WrEn === 1'b1) wq.push_back(pack(int'(WrAddr), int'(WrTone), int'(WrNote)));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [TONE_W-1:0] tone, input logic tick);
        @(negedge CLK);
        TONE_IN = tone;
        TICK    = tick;
    endtask

    // A run: tone seen by the DUT on a non-TICK cycle, then n clean TICKs.
    task automatic run(input logic [TONE_W-1:0] tone, input int n);
        drive(tone, 1'b0);
        drive(tone, 1'b0);
        for (int i = 0; i < n; i++) begin
            drive(tone, 1'b1);
            drive(tone, 1'b0);
        end
    endtask

    task automatic arm();
        @(negedge CLK);
        EN = 1'b1;
        TICK = 1'b0;
        TONE_IN = 7'd0;
        drive(7'd0, 1'b0);
    endtask

    task automatic stop();
        @(negedge CLK);
        EN = 1'b0;
        TICK = 1'b0;
        TONE_IN = 7'd0;
        for (int i = 0; i < 6; i++) drive(7'd0, 1'b0);
    endtask

    task automatic expw(input int a, input int t, input int n);
        eq.push_back(pack(a, t, n));
    endtask

    task automatic cmp_writes(input string tag);
        check($sformatf("%s_count", tag), wq.size(), eq.size());
        for (int i = 0; i < eq.size(); i++) begin
            check($sformatf("%s_w%0d", tag, i), (i < wq.size()) ? wq[i] : -1, eq[i]);
        end
        wq.delete();
        eq.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int k;
        logic [TONE_W-1:0] t;

        repeat (3) @(negedge CLK);
        check("rst_wren", WrEn, 1'b0);
        check("rst_rec", RECORDING, 1'b0);
        check("rst_full", FULL, 1'b0);
        check("rst_len", LENGTH, 0);
        check("rst_addr", WrAddr, 0);
        RST = 1'b1;
        drive(7'd0, 1'b0);
        drive(7'd0, 1'b0);
        check("rst_nowrite", wq.size(), 0);

        // 1: leading rest skipped, trailing rest dropped
        arm();
        check("t1_rec_armed", RECORDING, 1'b1);
        run(7'd0, 5);
        run(7'd40, 3);
        run(7'd0, 2);
        stop();
        expw(0, 40, 3); expw(1, 0, 0);
        cmp_writes("t1");
        check("t1_len", LENGTH, 1);
        check("t1_rec", RECORDING, 1'b0);
        check("t1_full", FULL, 1'b0);

        // 2: saturation splits a long note
        arm();
        run(7'd52, 130);
        run(7'd0, 1);
        stop();
        expw(0, 52, 127); expw(1, 52, 3); expw(2, 0, 0);
        cmp_writes("t2");
        check("t2_len", LENGTH, 2);

        // 3: TICK coinciding with a change credits the old tone
        arm();
        run(7'd30, 4);
        drive(7'd31, 1'b0);
        drive(7'd31, 1'b1);
        drive(7'd31, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(7'd31, 1'b1);
            drive(7'd31, 1'b0);
        end
        run(7'd0, 1);
        stop();
        expw(0, 30, 5); expw(1, 31, 2); expw(2, 0, 0);
        cmp_writes("t3");

        // 5: one-cycle glitch 40 -> 41 -> 40
        arm();
        run(7'd40, 3);
        drive(7'd41, 1'b0);
        run(7'd40, 2);
        run(7'd0, 1);
        stop();
`ifdef MUSIC_REC_GLITCH_FILTER_EN
        expw(0, 40, 5); expw(1, 0, 0);
        cmp_writes("t5");
        check("t5_len", LENGTH, 1);
`else
        expw(0, 40, 3); expw(1, 41, 1); expw(2, 40, 2); expw(3, 0, 0);
        cmp_writes("t5");
        check("t5_len", LENGTH, 3);
`endif

        // empty take: EN drops while still ARMED
        arm();
        stop();
        expw(0, 0, 0);
        cmp_writes("te");
        check("te_len", LENGTH, 0);

        // 4: fill the RAM with alternating one-TICK runs
        arm();
        k = 0;
        while (FULL !== 1'b1 && k < 1100) begin
            t = (k % 2 == 0) ? 7'd10 : 7'd11;
            drive(t, 1'b0);
            drive(t, 1'b1);
            k++;
        end
        check("t4_full_reached", FULL, 1'b1);
        for (int i = 0; i < 10; i++) begin
            t = (i % 2 == 0) ? 7'd12 : 7'd13;
            drive(t, 1'b0);
            drive(t, 1'b1);
        end
        check("t4_count", wq.size(), 1024);
        bad = 0;
        for (int i = 0; i < 1023 && i < wq.size(); i++) begin
            if (wq[i] != pack(i, (i % 2 == 0) ? 10 : 11, 1)) bad++;
        end
        check("t4_data_bad", bad, 0);
        check("t4_term", (wq.size() > 0) ? wq[wq.size() - 1] : -1, pack(1023, 0, 0));
        check("t4_len", LENGTH, 1023);
        check("t4_no_restart", RECORDING, 1'b0);
        wq.delete();
        stop();
        check("t4_full_hold", FULL, 1'b1);
        check("t4_len_hold", LENGTH, 1023);

        // 6: reset in the middle of a take
        arm();
        check("t6_full_clr", FULL, 1'b0);
        check("t6_len_clr", LENGTH, 0);
        run(7'd20, 2);
        run(7'd21, 1);
        drive(7'd21, 1'b0);
        check("t6_len_pre", LENGTH, 1);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("t6_wren", WrEn, 1'b0);
        check("t6_rec", RECORDING, 1'b0);
        check("t6_len", LENGTH, 0);
        check("t6_full", FULL, 1'b0);
        EN = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        drive(7'd0, 1'b0);
        drive(7'd0, 1'b0);
        expw(0, 20, 2);
        cmp_writes("t6a");
        arm();
        run(7'd22, 1);
        run(7'd0, 1);
        stop();
        expw(0, 22, 1); expw(1, 0, 0);
        cmp_writes("t6b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
